cpu_io_unit: RTL

Parametrised board I/O unit for the single-cycle CPU: it serves the IN instruction from the FPGA switches with a debounced confirm-button handshake, and serves the OUT instruction by converting the written word to decimal on a configurable number of seven-segment digits. It replaces fixed-width, directly decoded switch/display wiring between the processing unit and the board pins. It stalls the CPU while an input is pending and buffers one output write during conversion.

---
 rtl/cpu_io_unit_if.sv | 22 ++
 rtl/cpu_io_unit.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_io_unit_if.sv
// CPU-side bus of cpu_io_unit: IN request/ack handshake and OUT write port.
interface cpu_io_unit_if #(
  parameter int unsigned DATA_W = 32
);
  logic              in_req;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              stall_c;
  logic              out_write;
  logic [DATA_W-1:0] out_data;
  logic              out_busy;

  modport master (
    output in_req, out_write, out_data,
    input  in_data, in_valid, stall_c, out_busy
  );

  modport slave (
    input  in_req, out_write, out_data,
    output in_data, in_valid, stall_c, out_busy
  );
endinterface

// File: rtl/cpu_io_unit.sv
// Board I/O unit: debounced switch input for IN, binary-to-decimal 7-seg display for OUT.
// Optional SIGNED_DISPLAY_EN: two's-complement display with a leading minus digit.
module cpu_io_unit #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned SW_W         = 11,
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned DEBOUNCE_CYC = 16
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [SW_W-1:0]     i_fpga_switches,
  input  logic                i_confirm,
  cpu_io_unit_if.slave        io_cpu,
  output logic [7*DIGITS-1:0] o_display,
  output logic [SW_W-1:0]     o_leds
);

  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYC);
  localparam int unsigned BIT_W  = $clog2(DATA_W);
  localparam int unsigned BCD_W  = 4 * DIGITS;
  localparam int unsigned DISP_W = 7 * DIGITS;
  localparam logic [6:0]  SEG_BLANK = 7'h7F;
  localparam logic [6:0]  SEG_DASH  = 7'h3F;
  localparam logic [DISP_W-1:0] DISP_RST = {DIGITS{SEG_BLANK}} ^ DISP_W'(7'h3F);

  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned p;
    p = 64'd1;
    for (int unsigned k = 0; k < n; k++) p = p * 64'd10;
    return p;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return SEG_BLANK;
    endcase
  endfunction

  // One double-dabble step: add-3 correction on every digit, then shift in the next binary bit.
  function automatic logic [BCD_W-1:0] dabble(input logic [BCD_W-1:0] b, input logic bit_in);
    logic [BCD_W-1:0] t;
    t = b;
    for (int i = 0; i < int'(DIGITS); i++)
      if (t[4*i +: 4] >= 4'd5) t[4*i +: 4] = t[4*i +: 4] + 4'd3;
    return {t[BCD_W-2:0], bit_in};
  endfunction

  function automatic logic [DISP_W-1:0] fmt(input logic [BCD_W-1:0] bcd, input logic ovf,
                                            input logic neg);
    logic [DISP_W-1:0] d;
    logic              lead;
    logic [3:0]        dig;
    d    = '0;
    lead = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      dig = bcd[4*i +: 4];
      if (ovf)                               d[7*i +: 7] = SEG_DASH;
      else if (lead && dig == 4'd0 && i != 0) d[7*i +: 7] = SEG_BLANK;
      else begin
        d[7*i +: 7] = seg7(dig);
        lead        = 1'b0;
      end
    end
    if (neg && !ovf) d[DISP_W-1 -: 7] = SEG_DASH;
    return d;
  endfunction

  typedef enum logic [1:0] {IN_IDLE, IN_WAIT, IN_ACK} in_state_e;
  typedef enum logic [1:0] {OUT_IDLE, OUT_CHECK, OUT_CONVERT, OUT_COMMIT} out_state_e;

  logic [SW_W-1:0]   r_sw_s1, r_sw_s2;
  logic              r_cf_s1, r_cf_s2, r_db_level, r_press;
  logic [DB_W-1:0]   r_db_cnt;
  in_state_e         r_in_state, w_in_nxt;
  logic [DATA_W-1:0] r_in_data, w_in_data_nxt;
  logic              r_in_valid, w_in_valid_nxt;
  out_state_e        r_out_state, w_out_nxt;
  logic [DATA_W-1:0] r_val, w_val_nxt, r_pend_data, w_pend_data_nxt, r_shift, w_shift_nxt;
  logic [DATA_W-1:0] w_mag;
  logic              r_pend_vld, w_pend_vld_nxt, r_neg, w_neg_nxt, r_ovf, w_ovf_nxt;
  logic              w_neg, r_out_busy;
  logic [BCD_W-1:0]  r_bcd, w_bcd_nxt;
  logic [BIT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [DISP_W-1:0] r_display, w_display_nxt;

`ifdef SIGNED_DISPLAY_EN
  localparam longint unsigned OVF_LIMIT = pow10(DIGITS - 1);
  assign w_neg = r_val[DATA_W-1];
  assign w_mag = w_neg ? DATA_W'(-r_val) : r_val;
`else
  localparam longint unsigned OVF_LIMIT = pow10(DIGITS);
  assign w_neg = 1'b0;
  assign w_mag = r_val;
`endif

  // Synchronisers and Confirm debouncer; r_press marks the debounced rising edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sw_s1    <= '0;
      r_sw_s2    <= '0;
      r_cf_s1    <= 1'b0;
      r_cf_s2    <= 1'b0;
      r_db_level <= 1'b0;
      r_db_cnt   <= '0;
      r_press    <= 1'b0;
    end else begin
      r_sw_s1 <= i_fpga_switches;
      r_sw_s2 <= r_sw_s1;
      r_cf_s1 <= i_confirm;
      r_cf_s2 <= r_cf_s1;
      r_press <= 1'b0;
      if (r_cf_s2 == r_db_level) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_W'(DEBOUNCE_CYC - 1)) begin
        r_db_cnt   <= '0;
        r_db_level <= r_cf_s2;
        r_press    <= r_cf_s2;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_in_nxt       = r_in_state;
    w_in_data_nxt  = r_in_data;
    w_in_valid_nxt = 1'b0;
    case (r_in_state)
      IN_IDLE: if (io_cpu.in_req) w_in_nxt = IN_WAIT;
      IN_WAIT: begin
        if (!io_cpu.in_req) begin
          w_in_nxt = IN_IDLE;
        end else if (r_press) begin
          w_in_nxt       = IN_ACK;
          w_in_data_nxt  = DATA_W'(r_sw_s2);
          w_in_valid_nxt = 1'b1;
        end
      end
      default: w_in_nxt = IN_IDLE;
    endcase
  end

  always_comb begin
    w_out_nxt       = r_out_state;
    w_val_nxt       = r_val;
    w_pend_data_nxt = r_pend_data;
    w_pend_vld_nxt  = r_pend_vld;
    w_shift_nxt     = r_shift;
    w_bcd_nxt       = r_bcd;
    w_cnt_nxt       = r_cnt;
    w_ovf_nxt       = r_ovf;
    w_neg_nxt       = r_neg;
    w_display_nxt   = r_display;
    case (r_out_state)
      OUT_IDLE: begin
        if (io_cpu.out_write) begin
          w_val_nxt = io_cpu.out_data;
          w_out_nxt = OUT_CHECK;
        end
      end
      OUT_CHECK: begin
        w_neg_nxt   = w_neg;
        w_shift_nxt = w_mag;
        if (64'(w_mag) >= OVF_LIMIT) begin
          w_ovf_nxt = 1'b1;
          w_out_nxt = OUT_COMMIT;
        end else begin
          w_ovf_nxt = 1'b0;
          w_bcd_nxt = '0;
          w_cnt_nxt = '0;
          w_out_nxt = OUT_CONVERT;
        end
      end
      OUT_CONVERT: begin
        w_bcd_nxt   = dabble(r_bcd, r_shift[DATA_W-1]);
        w_shift_nxt = {r_shift[DATA_W-2:0], 1'b0};
        w_cnt_nxt   = r_cnt + 1'b1;
        if (r_cnt == BIT_W'(DATA_W - 1)) w_out_nxt = OUT_COMMIT;
      end
      OUT_COMMIT: begin
        // A write landing in COMMIT is the newest value, so it supersedes any pending one.
        w_display_nxt  = fmt(r_bcd, r_ovf, r_neg);
        w_pend_vld_nxt = 1'b0;
        if (io_cpu.out_write) begin
          w_val_nxt = io_cpu.out_data;
          w_out_nxt = OUT_CHECK;
        end else if (r_pend_vld) begin
          w_val_nxt = r_pend_data;
          w_out_nxt = OUT_CHECK;
        end else begin
          w_out_nxt = OUT_IDLE;
        end
      end
      default: w_out_nxt = OUT_IDLE;
    endcase
    if (io_cpu.out_write && (r_out_state == OUT_CHECK || r_out_state == OUT_CONVERT)) begin
      w_pend_data_nxt = io_cpu.out_data;
      w_pend_vld_nxt  = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_in_state  <= IN_IDLE;
      r_in_data   <= '0;
      r_in_valid  <= 1'b0;
      r_out_state <= OUT_IDLE;
      r_val       <= '0;
      r_pend_data <= '0;
      r_pend_vld  <= 1'b0;
      r_shift     <= '0;
      r_bcd       <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_neg       <= 1'b0;
      r_display   <= DISP_RST;
      r_out_busy  <= 1'b0;
    end else begin
      r_in_state  <= w_in_nxt;
      r_in_data   <= w_in_data_nxt;
      r_in_valid  <= w_in_valid_nxt;
      r_out_state <= w_out_nxt;
      r_val       <= w_val_nxt;
      r_pend_data <= w_pend_data_nxt;
      r_pend_vld  <= w_pend_vld_nxt;
      r_shift     <= w_shift_nxt;
      r_bcd       <= w_bcd_nxt;
      r_cnt       <= w_cnt_nxt;
      r_ovf       <= w_ovf_nxt;
      r_neg       <= w_neg_nxt;
      r_display   <= w_display_nxt;
      r_out_busy  <= (w_out_nxt != OUT_IDLE) || w_pend_vld_nxt;
    end
  end

  assign io_cpu.in_data  = r_in_data;
  assign io_cpu.in_valid = r_in_valid;
  assign io_cpu.stall_c  = io_cpu.in_req & ~r_in_valid;
  assign io_cpu.out_busy = r_out_busy;
  assign o_display       = r_display;
  assign o_leds          = r_sw_s2;

endmodule
